// File: rtl/bf_pkg.sv
// Shared types and arithmetic helpers for the radix-2 DIF butterfly.
// BF_LAT is the fixed pipeline depth. Helper arithmetic runs at BF_MAXW
// bits, which supports data widths up to 35 bits.
package bf_pkg;

    localparam int BF_LAT  = 3;
    localparam int BF_DW   = 16;
    localparam int BF_MAXW = 72;
    localparam logic signed [BF_MAXW-1:0] BF_ONE = {{(BF_MAXW-1){1'b0}}, 1'b1};

    // Complex sample at the default operand width
    typedef struct packed {
        logic signed [BF_DW-1:0] re;
        logic signed [BF_DW-1:0] im;
    } cplx_t;

    // Arithmetic right shift with round-half-up; a shift of 0 passes the value through
    function automatic logic signed [BF_MAXW-1:0] rnd_shift(
        input logic signed [BF_MAXW-1:0] value,
        input int                        shift
    );
        logic signed [BF_MAXW-1:0] r;
        if (shift > 0) begin
            r = (value + (BF_ONE <<< (shift - 1))) >>> shift;
        end else begin
            r = value;
        end
        return r;
    endfunction

    // Round, then clamp into the signed range of 'width' bits
    function automatic logic signed [BF_MAXW-1:0] sat_round(
        input logic signed [BF_MAXW-1:0] value,
        input int                        shift,
        input int                        width
    );
        logic signed [BF_MAXW-1:0] r;
        logic signed [BF_MAXW-1:0] hi;
        logic signed [BF_MAXW-1:0] lo;
        r  = rnd_shift(value, shift);
        hi = (BF_ONE <<< (width - 1)) - BF_ONE;
        lo = -(BF_ONE <<< (width - 1));
        if (r > hi) begin
            return hi;
        end else if (r < lo) begin
            return lo;
        end else begin
            return r;
        end
    endfunction

    // High when sat_round would clip the same value
    function automatic logic sat_clip(
        input logic signed [BF_MAXW-1:0] value,
        input int                        shift,
        input int                        width
    );
        logic signed [BF_MAXW-1:0] r;
        logic signed [BF_MAXW-1:0] hi;
        logic signed [BF_MAXW-1:0] lo;
        r  = rnd_shift(value, shift);
        hi = (BF_ONE <<< (width - 1)) - BF_ONE;
        lo = -(BF_ONE <<< (width - 1));
        return (r > hi) || (r < lo);
    endfunction

endpackage

// File: rtl/bf_radix2_pipe_cmul.sv
// bf_cmul_pipe: stages 2-3 of the butterfly, (diff * W) with rounding and saturation.
// Stage 2 registers the four partial products. Stage 3 combines them and
// registers the rounded result. The clip flag is combinational from stage 2
// so that the top level can fold it into its registered sat_flag.
module bf_cmul_pipe
    import bf_pkg::*;
#(
    parameter int DW    = 16,
    parameter int SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 adv2,
    input  logic                 adv3,
    input  logic signed [DW:0]   diff_re,
    input  logic signed [DW:0]   diff_im,
    input  logic signed [DW-1:0] w_re,
    input  logic signed [DW-1:0] w_im,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im,
    output logic                 y_clip
);

    localparam int PW = 2 * DW + 1;
    localparam int SW = 2 * DW + 2;

    logic signed [PW-1:0] rr_r, ii_r, ri_r, ir_r;
    logic signed [SW-1:0] p_re_s, p_im_s;
    logic signed [DW-1:0] y_re_s, y_im_s;

    // Stage 2: register the four partial products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r <= {PW{1'b0}};
            ii_r <= {PW{1'b0}};
            ri_r <= {PW{1'b0}};
            ir_r <= {PW{1'b0}};
        end else if (adv2) begin
            rr_r <= PW'(diff_re) * PW'(w_re);
            ii_r <= PW'(diff_im) * PW'(w_im);
            ri_r <= PW'(diff_re) * PW'(w_im);
            ir_r <= PW'(diff_im) * PW'(w_re);
        end
    end

    // Stage 3 datapath: combine the products, round and saturate
    always_comb begin
        p_re_s = SW'(rr_r) - SW'(ii_r);
        p_im_s = SW'(ri_r) + SW'(ir_r);
        y_re_s = DW'(sat_round(BF_MAXW'(p_re_s), SHIFT, DW));
        y_im_s = DW'(sat_round(BF_MAXW'(p_im_s), SHIFT, DW));
        y_clip = sat_clip(BF_MAXW'(p_re_s), SHIFT, DW) |
                 sat_clip(BF_MAXW'(p_im_s), SHIFT, DW);
    end

    // Stage 3 register: hold the last result unless a valid set advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_re <= {DW{1'b0}};
            y_im <= {DW{1'b0}};
        end else if (adv3) begin
            y_re <= y_re_s;
            y_im <= y_im_s;
        end
    end

endmodule

// File: rtl/bf_radix2_pipe.sv
// bf_radix2_pipe: 3-stage pipelined radix-2 DIF butterfly.
//   Y0 = A + B,  Y1 = (A - B) * W,  rounded and saturated to DW bits.
// Optional macro BF_SCALE_EN: halves both outputs for per-stage FFT scaling.
// Flow control: the whole pipe freezes while the output is valid but not
// taken. Bubbles travel with the data and are not squeezed out.
module bf_radix2_pipe
    import bf_pkg::*;
#(
    parameter int DW    = 16,
    parameter int WFRAC = 8,
    parameter int LAT   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [DW-1:0] w_re,
    input  logic signed [DW-1:0] w_im,
    input  logic                 w_bypass,
    output logic signed [DW-1:0] y0_re,
    output logic signed [DW-1:0] y0_im,
    output logic signed [DW-1:0] y1_re,
    output logic signed [DW-1:0] y1_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sat_flag
);

`ifdef BF_SCALE_EN
    localparam int Y0_SH = 1;
    localparam int Y1_SH = WFRAC + 1;
`else
    localparam int Y0_SH = 0;
    localparam int Y1_SH = WFRAC;
`endif

    localparam int SW1 = DW + 1;
    localparam logic signed [DW-1:0] W_ONE = {{(DW-1){1'b0}}, 1'b1} << WFRAC;

    generate
        if (LAT != BF_LAT) begin : g_bad_lat
            $error("bf_radix2_pipe: LAT is fixed at 3");
        end
        if ((WFRAC < 1) || (WFRAC > DW - 2)) begin : g_bad_wfrac
            $error("bf_radix2_pipe: WFRAC must lie in 1..DW-2");
        end
        if (2 * DW + 2 > BF_MAXW) begin : g_bad_dw
            $error("bf_radix2_pipe: DW too wide for bf_pkg helpers");
        end
    endgenerate

    logic                 stall_s, adv_s, adv1_s, adv2_s, adv3_s;
    logic                 v1_r, v2_r;
    logic signed [DW:0]   sum_re_r, sum_im_r, diff_re_r, diff_im_r;
    logic signed [DW:0]   sum2_re_r, sum2_im_r;
    logic signed [DW-1:0] wr_r, wi_r, w_sel_re_s, w_sel_im_s;
    logic signed [DW-1:0] y0_re_s, y0_im_s;
    logic                 y0_clip_s, y1_clip_s;

    // Global stall: nothing moves while a valid result waits for the sink
    always_comb begin
        stall_s  = out_valid & ~out_ready;
        adv_s    = ~stall_s;
        in_ready = ~stall_s;
        adv1_s   = adv_s & in_valid;
        adv2_s   = adv_s & v1_r;
        adv3_s   = adv_s & v2_r;
    end

    // Twiddle select: bypass forces W to exactly 1.0 + j0
    always_comb begin
        if (w_bypass) begin
            w_sel_re_s = W_ONE;
            w_sel_im_s = {DW{1'b0}};
        end else begin
            w_sel_re_s = w_re;
            w_sel_im_s = w_im;
        end
    end

    // Stage valid chain; advances as a unit so bubbles are kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r      <= 1'b0;
            v2_r      <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv_s) begin
            v1_r      <= in_valid;
            v2_r      <= v1_r;
            out_valid <= v2_r;
        end
    end

    // Stage 1: full-precision sum/difference and the selected twiddle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_re_r  <= {SW1{1'b0}};
            sum_im_r  <= {SW1{1'b0}};
            diff_re_r <= {SW1{1'b0}};
            diff_im_r <= {SW1{1'b0}};
            wr_r      <= {DW{1'b0}};
            wi_r      <= {DW{1'b0}};
        end else if (adv1_s) begin
            sum_re_r  <= SW1'(a_re) + SW1'(b_re);
            sum_im_r  <= SW1'(a_im) + SW1'(b_im);
            diff_re_r <= SW1'(a_re) - SW1'(b_re);
            diff_im_r <= SW1'(a_im) - SW1'(b_im);
            wr_r      <= w_sel_re_s;
            wi_r      <= w_sel_im_s;
        end
    end

    // Stage 2: delay the sum alongside the multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum2_re_r <= {SW1{1'b0}};
            sum2_im_r <= {SW1{1'b0}};
        end else if (adv2_s) begin
            sum2_re_r <= sum_re_r;
            sum2_im_r <= sum_im_r;
        end
    end

    // Stage 3 Y0 datapath: optional halving, then saturation
    always_comb begin
        y0_re_s   = DW'(sat_round(BF_MAXW'(sum2_re_r), Y0_SH, DW));
        y0_im_s   = DW'(sat_round(BF_MAXW'(sum2_im_r), Y0_SH, DW));
        y0_clip_s = sat_clip(BF_MAXW'(sum2_re_r), Y0_SH, DW) |
                    sat_clip(BF_MAXW'(sum2_im_r), Y0_SH, DW);
    end

    // Stage 3 register for Y0 and the combined saturation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_re    <= {DW{1'b0}};
            y0_im    <= {DW{1'b0}};
            sat_flag <= 1'b0;
        end else if (adv3_s) begin
            y0_re    <= y0_re_s;
            y0_im    <= y0_im_s;
            sat_flag <= y0_clip_s | y1_clip_s;
        end
    end

    bf_cmul_pipe #(
        .DW    (DW),
        .SHIFT (Y1_SH)
    ) u_cmul (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv2    (adv2_s),
        .adv3    (adv3_s),
        .diff_re (diff_re_r),
        .diff_im (diff_im_r),
        .w_re    (wr_r),
        .w_im    (wi_r),
        .y_re    (y1_re),
        .y_im    (y1_im),
        .y_clip  (y1_clip_s)
    );

endmodule

// File: tb/tb_bf_radix2_pipe.sv
// Self-checking bench for bf_radix2_pipe (DW=16, WFRAC=8).
// Hand-computed vectors plus a behavioural model feeding a scoreboard queue.
// Honours BF_SCALE_EN in both the vector table and the model.
module tb_bf_radix2_pipe;
    import bf_pkg::*;

    localparam int DW    = 16;
    localparam int WFRAC = 8;
`ifdef BF_SCALE_EN
    localparam int Y0_SH = 1;
    localparam int Y1_SH = WFRAC + 1;
`else
    localparam int Y0_SH = 0;
    localparam int Y1_SH = WFRAC;
`endif

    typedef struct { cplx_t y0; cplx_t y1; logic sat; } exp_t;
    typedef struct { cplx_t a; cplx_t b; cplx_t w; logic byp; exp_t e; } vec_t;

    logic clk, rst_n, in_valid, in_ready, w_bypass, out_valid, out_ready, sat_flag;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic signed [DW-1:0] y0_re, y0_im, y1_re, y1_im;

    exp_t sb_q[$];
    vec_t tbl[6];
    vec_t rv[12];
    int   errors = 0;
    int   checks = 0;
    int   sent   = 0;
    int   recvd  = 0;

    bf_radix2_pipe #(.DW(DW), .WFRAC(WFRAC), .LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .w_re(w_re), .w_im(w_im), .w_bypass(w_bypass),
        .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
        .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cplx_t cx(input int re, input int im);
        cplx_t c;
        c.re = 16'(re);
        c.im = 16'(im);
        return c;
    endfunction

    function automatic exp_t mk_exp(input int y0r, input int y0i, input int y1r, input int y1i, input logic s);
        exp_t e;
        e.y0  = cx(y0r, y0i);
        e.y1  = cx(y1r, y1i);
        e.sat = s;
        return e;
    endfunction

    function automatic vec_t mk_vec(input cplx_t a, input cplx_t b, input cplx_t w, input logic byp, input exp_t e);
        vec_t v;
        v.a = a; v.b = b; v.w = w; v.byp = byp; v.e = e;
        return v;
    endfunction

    // floor(n / 2^s) using true division, corrected for negative remainders
    function automatic longint floor_div_pow2(input longint n, input int s);
        longint d, q;
        d = 64'sd1 << s;
        q = n / d;
        if ((n % d != 64'sd0) && (n < 64'sd0)) q = q - 64'sd1;
        return q;
    endfunction

    function automatic logic signed [15:0] clamp16(input longint v, output logic clip);
        clip = 1'b1;
        if (v > 64'sd32767) return 16'sh7fff;
        if (v < -64'sd32768) return 16'sh8000;
        clip = 1'b0;
        return 16'(v);
    endfunction

    function automatic exp_t model(input cplx_t a, input cplx_t b, input cplx_t w, input logic byp);
        exp_t   e;
        longint sr, si, dr, di, wr, wi, pr, pi, r0, r1;
        logic   c0, c1, c2, c3;
        sr = longint'(a.re) + longint'(b.re);
        si = longint'(a.im) + longint'(b.im);
        dr = longint'(a.re) - longint'(b.re);
        di = longint'(a.im) - longint'(b.im);
        wr = byp ? (64'sd1 << WFRAC) : longint'(w.re);
        wi = byp ? 64'sd0 : longint'(w.im);
        pr = dr * wr - di * wi;
        pi = dr * wi + di * wr;
        r0 = (64'sd1 << Y0_SH) / 64'sd2;
        r1 = (64'sd1 << Y1_SH) / 64'sd2;
        e.y0.re = clamp16(floor_div_pow2(sr + r0, Y0_SH), c0);
        e.y0.im = clamp16(floor_div_pow2(si + r0, Y0_SH), c1);
        e.y1.re = clamp16(floor_div_pow2(pr + r1, Y1_SH), c2);
        e.y1.im = clamp16(floor_div_pow2(pi + r1, Y1_SH), c3);
        e.sat   = c0 | c1 | c2 | c3;
        return e;
    endfunction

    function automatic vec_t rand_vec();
        cplx_t a, b, w;
        logic  byp;
        a   = cx(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        b   = cx(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        w   = cx(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
        byp = 1'($urandom_range(0, 1));
        return mk_vec(a, b, w, byp, model(a, b, w, byp));
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Call at a falling edge; returns at the falling edge after the transfer
    task automatic send(input vec_t v);
        int waitc;
        a_re = v.a.re; a_im = v.a.im; b_re = v.b.re; b_im = v.b.im;
        w_re = v.w.re; w_im = v.w.im; w_bypass = v.byp; in_valid = 1'b1;
        waitc = 0;
        #1;
        while (!in_ready && waitc < 50) begin
            @(negedge clk); #1;
            waitc++;
        end
        if (!in_ready) begin
            errors++; checks++;
            $display("FAIL send_timeout: in_ready stayed %0b for %0d cycles", in_ready, waitc);
        end else begin
            sb_q.push_back(v.e);
            sent++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int c = 0; c < 60 && sb_q.size() != 0; c++) @(negedge clk);
        chk("drain_queue_empty", sb_q.size(), 0);
    endtask

    // Scoreboard monitor: compares each result that the sink accepts
    always begin : mon
        exp_t e;
        @(negedge clk); #2;
        if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: y0=(%0d,%0d) y1=(%0d,%0d) with empty scoreboard",
                         y0_re, y0_im, y1_re, y1_im);
            end else begin
                e = sb_q.pop_front();
                recvd++;
                if (y0_re !== e.y0.re || y0_im !== e.y0.im || y1_re !== e.y1.re ||
                    y1_im !== e.y1.im || sat_flag !== e.sat) begin
                    errors++;
                    $display("FAIL result[%0d]: got y0=(%0d,%0d) y1=(%0d,%0d) sat=%0b expected y0=(%0d,%0d) y1=(%0d,%0d) sat=%0b",
                             recvd, y0_re, y0_im, y1_re, y1_im, sat_flag,
                             e.y0.re, e.y0.im, e.y1.re, e.y1.im, e.sat);
                end
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [63:0] zero_out;
        zero_out = 64'd0;
`ifdef BF_SCALE_EN
        tbl[0] = mk_vec(cx(-130, -567), cx(-770, -392), cx(256, 25), 1'b0, mk_exp(-450, -479, 329, -56, 1'b0));
        tbl[1] = mk_vec(cx(-130, -567), cx(-770, -392), cx(256, 25), 1'b1, mk_exp(-450, -479, 320, -87, 1'b0));
        tbl[2] = mk_vec(cx(32767, -32768), cx(32767, -32768), cx(256, 0), 1'b0, mk_exp(32767, -32768, 0, 0, 1'b0));
        tbl[3] = mk_vec(cx(20000, 20000), cx(0, 0), cx(256, 256), 1'b0, mk_exp(10000, 10000, 0, 20000, 1'b0));
        tbl[4] = mk_vec(cx(100, -200), cx(-50, 25), cx(-32768, 32767), 1'b1, mk_exp(25, -87, 75, -112, 1'b0));
        tbl[5] = mk_vec(cx(-20000, 0), cx(20000, 0), cx(256, 0), 1'b0, mk_exp(0, 0, -20000, 0, 1'b0));
`else
        tbl[0] = mk_vec(cx(-130, -567), cx(-770, -392), cx(256, 25), 1'b0, mk_exp(-900, -959, 657, -112, 1'b0));
        tbl[1] = mk_vec(cx(-130, -567), cx(-770, -392), cx(256, 25), 1'b1, mk_exp(-900, -959, 640, -175, 1'b0));
        tbl[2] = mk_vec(cx(32767, -32768), cx(32767, -32768), cx(256, 0), 1'b0, mk_exp(32767, -32768, 0, 0, 1'b1));
        tbl[3] = mk_vec(cx(20000, 20000), cx(0, 0), cx(256, 256), 1'b0, mk_exp(20000, 20000, 0, 32767, 1'b1));
        tbl[4] = mk_vec(cx(100, -200), cx(-50, 25), cx(-32768, 32767), 1'b1, mk_exp(50, -175, 150, -225, 1'b0));
        tbl[5] = mk_vec(cx(-20000, 0), cx(20000, 0), cx(256, 0), 1'b0, mk_exp(0, 0, -32768, 0, 1'b1));
`endif
        for (int i = 0; i < 12; i++) rv[i] = rand_vec();

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; w_bypass = 1'b0;
        a_re = 16'sd0; a_im = 16'sd0; b_re = 16'sd0; b_im = 16'sd0; w_re = 16'sd0; w_im = 16'sd0;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_outputs", longint'({y0_re, y0_im, y1_re, y1_im}), longint'(zero_out));
        chk("reset_sat_flag", sat_flag, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: one isolated set, valid exactly three edges after presentation
        send(tbl[0]);
        #2 chk("latency_edge1", out_valid, 0);
        @(negedge clk); #2 chk("latency_edge2", out_valid, 0);
        @(negedge clk); #2 chk("latency_edge3", out_valid, 1);
        @(negedge clk); #2 chk("idle_out_valid", out_valid, 0);
        chk("idle_hold_y0_re", y0_re, tbl[0].e.y0.re);
        @(negedge clk);

        // Vector table, back to back
        for (int i = 0; i < 6; i++) send(tbl[i]);
        drain();

        // Eight-set stream with a four-cycle downstream stall in the middle
        sent = 0; recvd = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(rv[i]);
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    #2;
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_hold", longint'({y0_re, y0_im, y1_re, y1_im}),
                        longint'({sb_q[0].y0.re, sb_q[0].y0.im, sb_q[0].y1.re, sb_q[0].y1.im}));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", recvd, sent);

        // Reset with three sets in flight
        for (int i = 8; i < 11; i++) send(rv[i]);
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_outputs", longint'({y0_re, y0_im, y1_re, y1_im}), longint'(zero_out));
        chk("midreset_sat_flag", sat_flag, 0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #2;
            chk("post_reset_no_output", out_valid, 0);
        end
        @(negedge clk);
        send(tbl[3]);
        drain();

        // Random stream against a randomly throttled sink
        fork
            begin
                for (int i = 0; i < 12; i++) send(rand_vec());
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
